// File: rtl/game_countdown_timer.sv
// Millisecond countdown timer: a prescaler turns clk into 1 ms ticks that count down a loaded
// game duration. It also keeps a BCD seconds readout (ceil of the remaining seconds).
module game_countdown_timer #(
   parameter int unsigned CYCLES_PER_MS = 50000,
   parameter int unsigned MAX_SECONDS   = 99,
   parameter int unsigned TMW           = $clog2(MAX_SECONDS * 1000 + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [6:0]     load_seconds,
   input  logic           pause,
   output logic [TMW-1:0] timer_milliseconds,
   output logic           ms_tick,
   output logic           expired,
   output logic           running,
   output logic [3:0]     sec_tens,
   output logic [3:0]     sec_ones
);

   localparam int unsigned PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [6:0] MaxSec = 7'(MAX_SECONDS);
   localparam logic [PW-1:0] PrescLast = PW'(CYCLES_PER_MS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

   state_e        state;
   logic [PW-1:0] prescaler;
   logic [9:0]    frac;

   logic [6:0]     load_n;
   logic [3:0]     load_tens;
   logic [3:0]     load_ones;
   logic [TMW-1:0] load_ms;
   logic           terminal;

   always_comb begin
      load_n    = (load_seconds > MaxSec) ? MaxSec : load_seconds;
      load_tens = 4'(load_n / 7'd10);
      load_ones = 4'(load_n % 7'd10);
      load_ms   = TMW'(32'(load_n) * 32'd1000);
      terminal  = (prescaler == PrescLast);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= StIdle;
         prescaler          <= '0;
         frac               <= '0;
         timer_milliseconds <= '0;
         ms_tick            <= 1'b0;
         expired            <= 1'b0;
         running            <= 1'b0;
         sec_tens           <= '0;
         sec_ones           <= '0;
      end else begin
         ms_tick <= 1'b0;
         expired <= 1'b0;
         if (load) begin
            timer_milliseconds <= load_ms;
            prescaler          <= '0;
            frac               <= '0;
            sec_tens           <= load_tens;
            sec_ones           <= load_ones;
            if (load_n != 7'd0) begin
               state   <= StRun;
               running <= 1'b1;
            end else begin
               state   <= StDone;
               running <= 1'b0;
               expired <= 1'b1;
            end
         end else begin
            unique case (state)
               StRun: begin
                  // A pause arriving on the terminal count defers the decrement.
                  if (pause) begin
                     state <= StPaused;
                  end else if (terminal) begin
                     prescaler          <= '0;
                     timer_milliseconds <= timer_milliseconds - TMW'(1);
                     ms_tick            <= 1'b1;
                     frac               <= (frac == 10'd0) ? 10'd999 : frac - 10'd1;
                     // frac 1->0 means ms just landed on a whole second.
                     if (frac == 10'd1) begin
                        if (sec_ones == 4'd0) begin
                           sec_ones <= 4'd9;
                           sec_tens <= sec_tens - 4'd1;
                        end else begin
                           sec_ones <= sec_ones - 4'd1;
                        end
                     end
                     if (timer_milliseconds == TMW'(1)) begin
                        expired <= 1'b1;
                        running <= 1'b0;
                        state   <= StDone;
                     end
                  end else begin
                     prescaler <= prescaler + PW'(1);
                  end
               end
               StPaused: begin
                  if (!pause) state <= StRun;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
